// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-ported register file slice.
package rf_pkg;

  localparam int unsigned RF_MAX_RD_PORTS = 4;
  localparam int unsigned RF_MAX_WR_PORTS = 2;
  localparam int unsigned ZERO_REG        = 0;

  function automatic int unsigned rf_addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: read, write and issue ports.
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_CNT  = 32,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 1
);
  localparam int unsigned AW = rf_addr_w(REG_CNT);

  logic [RD_PORTS*AW-1:0]   rd_addr;
  logic [RD_PORTS*XLEN-1:0] rd_data;
  logic [RD_PORTS-1:0]      rd_busy;
  logic [WR_PORTS-1:0]      wr_en;
  logic [WR_PORTS*AW-1:0]   wr_addr;
  logic [WR_PORTS*XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic [REG_CNT-1:0]       busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: issue sets, writeback clears, issue wins a same-cycle tie.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned REG_CNT  = 32,
  parameter int unsigned WR_PORTS = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [WR_PORTS-1:0]                      wr_en,
  input  logic [WR_PORTS*rf_addr_w(REG_CNT)-1:0]   wr_addr,
  input  logic                                     iss_en,
  input  logic [rf_addr_w(REG_CNT)-1:0]            iss_addr,
  output logic [REG_CNT-1:0]                       busy_nxt,
  output logic [REG_CNT-1:0]                       busy_q
);
  localparam int unsigned AW = rf_addr_w(REG_CNT);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  always_comb begin
    busy_nxt = busy_q;
    for (int unsigned k = 0; k < WR_PORTS; k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported GPR file: registered reads, optional write-to-read bypass, busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_CNT  = 32,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW = rf_addr_w(REG_CNT);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  generate
    if (RD_PORTS == 0 || RD_PORTS > RF_MAX_RD_PORTS ||
        WR_PORTS == 0 || WR_PORTS > RF_MAX_WR_PORTS ||
        REG_CNT < 2 || (REG_CNT & (REG_CNT - 1)) != 0) begin : g_param_check
      $error("regfile_mp: illegal parameter set");
    end
  endgenerate

  logic [XLEN-1:0]    regs [REG_CNT];
  logic [AW-1:0]      wa [WR_PORTS];
  logic [XLEN-1:0]    wd [WR_PORTS];
  logic [AW-1:0]      ra [RD_PORTS];
  logic [XLEN-1:0]    rd_d [RD_PORTS];
  logic [XLEN-1:0]    rd_q [RD_PORTS];
  logic [RD_PORTS-1:0] rd_busy_d;
  logic [RD_PORTS-1:0] rd_busy_q;
  logic [REG_CNT-1:0] busy_nxt;

  for (genvar k = 0; k < WR_PORTS; k++) begin : g_wr
    assign wa[k] = bus.wr_addr[k*AW +: AW];
    assign wd[k] = bus.wr_data[k*XLEN +: XLEN];
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    assign ra[i] = bus.rd_addr[i*AW +: AW];
    assign bus.rd_data[i*XLEN +: XLEN] = rd_q[i];
  end

  assign bus.rd_busy = rd_busy_q;

  rf_scoreboard #(
    .REG_CNT  (REG_CNT),
    .WR_PORTS (WR_PORTS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .busy_nxt (busy_nxt),
    .busy_q   (bus.busy_vec)
  );

  // Ports are scanned low to high so the last NBA (highest index) wins a conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < REG_CNT; r++) regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
        if (bus.wr_en[k] && wa[k] != ZERO_ADDR) regs[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RD_PORTS; i++) begin
      rd_d[i]      = (ra[i] == ZERO_ADDR) ? '0 : regs[ra[i]];
      rd_busy_d[i] = busy_nxt[ra[i]];
      if (BYPASS != 0 && ra[i] != ZERO_ADDR) begin
        for (int unsigned k = 0; k < WR_PORTS; k++) begin
          if (bus.wr_en[k] && wa[k] == ra[i]) rd_d[i] = wd[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_PORTS; i++) rd_q[i] <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < RD_PORTS; i++) rd_q[i] <= rd_d[i];
      rd_busy_q <= rd_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance driven in lockstep.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  regfile_mp_if #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2), .WR_PORTS(2)) if_a ();
  regfile_mp_if #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2), .WR_PORTS(2)) if_b ();

  assign if_a.rd_addr = rd_addr;   assign if_b.rd_addr = rd_addr;
  assign if_a.wr_en = wr_en;       assign if_b.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr;   assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;   assign if_b.wr_data = wr_data;
  assign if_a.iss_en = iss_en;     assign if_b.iss_en = iss_en;
  assign if_a.iss_addr = iss_addr; assign if_b.iss_addr = iss_addr;

  regfile_mp #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  regfile_mp #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  typedef struct {
    string       name;
    logic [31:0] a0, a1, b0, b1;
    logic [1:0]  busy;
    logic [31:0] bv;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every edge with a pending expectation yields one set of comparisons.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".a0"},   if_a.rd_data[31:0],  e.a0);
      chk({e.name, ".a1"},   if_a.rd_data[63:32], e.a1);
      chk({e.name, ".b0"},   if_b.rd_data[31:0],  e.b0);
      chk({e.name, ".b1"},   if_b.rd_data[63:32], e.b1);
      chk({e.name, ".busyA"}, {30'd0, if_a.rd_busy}, {30'd0, e.busy});
      chk({e.name, ".busyB"}, {30'd0, if_b.rd_busy}, {30'd0, e.busy});
      chk({e.name, ".bvA"},  if_a.busy_vec, e.bv);
      chk({e.name, ".bvB"},  if_b.busy_vec, e.bv);
    end
  end

  task automatic idle_inputs();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  // One cycle of stimulus; the expected registered outputs after the next edge are queued.
  task automatic cyc(input string nm,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic [1:0] we,
                     input logic [4:0] w0a, input logic [31:0] w0d,
                     input logic [4:0] w1a, input logic [31:0] w1d,
                     input logic ie, input logic [4:0] ia,
                     input logic [31:0] ea0, input logic [31:0] ea1,
                     input logic [31:0] eb0, input logic [31:0] eb1,
                     input logic [1:0] ebusy, input logic [31:0] ebv);
    exp_t e;
    @(negedge clk);
    rd_addr = {r1, r0};
    wr_en = we; wr_addr = {w1a, w0a}; wr_data = {w1d, w0d};
    iss_en = ie; iss_addr = ia;
    e.name = nm; e.a0 = ea0; e.a1 = ea1; e.b0 = eb0; e.b1 = eb1; e.busy = ebusy; e.bv = ebv;
    exp_q.push_back(e);
  endtask

  initial begin
    idle_inputs();
    #3;
    chk("rst0.a0", if_a.rd_data[31:0], 32'h0);
    chk("rst0.bv", if_a.busy_vec, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    //   name    r0 r1 we    w0a w0d           w1a w1d           ie ia  a0            a1            b0            b1            busy  bv
    cyc("wr5",   5, 5, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0,         0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 32'h0);
    cyc("rd5",   5, 5, 2'b00, 0, 32'h0,        0, 32'h0,         0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);

    // Asynchronous reset mid-cycle, with a write and issue presented that must be lost.
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h00000001};
    iss_en = 1'b1; iss_addr = 5'd6;
    #1;
    chk("rst.a0", if_a.rd_data[31:0],  32'h0);
    chk("rst.a1", if_a.rd_data[63:32], 32'h0);
    chk("rst.b0", if_b.rd_data[31:0],  32'h0);
    chk("rst.bv", if_a.busy_vec,       32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    cyc("rst5",  5, 6, 2'b00, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 32'h0);
    cyc("x0w",   0, 7, 2'b11, 0, 32'h12345678, 7, 32'hA5A5A5A5, 0, 0, 32'h0,        32'hA5A5A5A5, 32'h0,        32'h0,        2'b00, 32'h0);
    cyc("x0r",   0, 7, 2'b00, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 2'b00, 32'h0);
    cyc("byp",   3, 7, 2'b01, 3, 32'h11,       0, 32'h0,         0, 0, 32'h11,       32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 2'b00, 32'h0);
    cyc("byp2",  3, 3, 2'b00, 0, 32'h0,        0, 32'h0,         0, 0, 32'h11,       32'h11,       32'h11,       32'h11,       2'b00, 32'h0);
    cyc("cnfw",  9, 9, 2'b11, 9, 32'hAA,       9, 32'hBB,        0, 0, 32'hBB,       32'hBB,       32'h0,        32'h0,        2'b00, 32'h0);
    cyc("cnfr",  9, 9, 2'b00, 0, 32'h0,        0, 32'h0,         0, 0, 32'hBB,       32'hBB,       32'hBB,       32'hBB,       2'b00, 32'h0);
    cyc("iss4",  4, 4, 2'b00, 0, 32'h0,        0, 32'h0,         1, 4, 32'h0,        32'h0,        32'h0,        32'h0,        2'b11, 32'h10);
    cyc("wb4",   4, 9, 2'b01, 4, 32'h44,       0, 32'h0,         0, 0, 32'h44,       32'hBB,       32'h0,        32'hBB,       2'b00, 32'h0);
    cyc("isswb", 4, 4, 2'b10, 0, 32'h0,        4, 32'h55,        1, 4, 32'h55,       32'h55,       32'h44,       32'h44,       2'b11, 32'h10);
    cyc("iss0",  0, 4, 2'b00, 0, 32'h0,        0, 32'h0,         1, 0, 32'h0,        32'h55,       32'h0,        32'h55,       2'b10, 32'h10);
    cyc("reiss", 4, 0, 2'b00, 0, 32'h0,        0, 32'h0,         1, 4, 32'h55,       32'h0,        32'h55,       32'h0,        2'b01, 32'h10);
    cyc("mix",   4, 12, 2'b01, 4, 32'h66,      0, 32'h0,         1, 12, 32'h66,      32'h0,        32'h55,       32'h0,        2'b10, 32'h1000);
    cyc("hold",  4, 12, 2'b00, 0, 32'h0,       0, 32'h0,         0, 0, 32'h66,       32'h0,        32'h66,       32'h0,        2'b10, 32'h1000);

    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-ported general-purpose register file with registered reads, same-cycle write-to-read bypass, asynchronous clear and an integrated busy scoreboard. It is the parametrised successor of the single-write/dual-read GPR file. It sits between decode (read/issue) and writeback (write ports) in the core pipeline. Register 0 is hardwired to zero and is never busy.

## Interface
- `XLEN`, 32: register width in bits.
- `REG_CNT`, 32: number of registers; power of two, ≥ 2.
- `RD_PORTS`, 2: number of read ports, 1..4.
- `WR_PORTS`, 1: number of write ports, 1..2.
- `BYPASS`, 1: 1 = same-cycle write data is forwarded to reads; 0 = reads return the pre-write value.
- `AW` (localparam) = $clog2(REG_CNT).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rd_addr`  in  RD_PORTS×AW: read addresses, packed with port 0 at the LSBs.
- `rd_data`  out  RD_PORTS×XLEN: registered read data.
- `rd_busy`  out  RD_PORTS: registered busy flag of the addressed register.
- `wr_en`  in  WR_PORTS: write enables.
- `wr_addr`  in  WR_PORTS×AW: write addresses.
- `wr_data`  in  WR_PORTS×XLEN: write data.
- `iss_en`  in  1: mark a destination register as busy (instruction issued).
- `iss_addr`  in  AW: register to mark busy.
- `busy_vec`  out  REG_CNT: current scoreboard, one bit per register, driven directly from the state.

## Operation
- **Writes.** If `wr_en[k]` is high and `wr_addr[k]` ≠ 0, the register takes `wr_data[k]` at the rising edge. Writes to register 0 are dropped.
- **Write conflict.** If two write ports target the same register in one cycle, the higher port index wins.
- **Reads.** `rd_data[i]` is loaded at each edge from the register at `rd_addr[i]`. Address 0 always returns 0.
- **Bypass with `BYPASS`=1.** If any enabled write targets `rd_addr[i]` (≠ 0) in the same cycle, the winning write's data is loaded instead of the stored value.
- **Bypass with `BYPASS`=0.** Reads load the old stored value.
- **Scoreboard next-state, per register r.**
  - Set when `iss_en` is high and `iss_addr` = r.
  - Else clear when any enabled write targets r.
  - Else hold.
  - Bit 0 is forced to 0.
- **Simultaneous issue and write to the same register:** the bit stays or becomes set. The new producer wins.
- **`rd_busy[i]`** is loaded with the scoreboard next-state of `rd_addr[i]`. This keeps it consistent with the bypassed data.
- Issuing to a register that is already busy is legal: the bit stays set, no error is raised.

## Timing
- Read latency is 1 cycle. The address is presented in cycle N; `rd_data` and `rd_busy` are valid after edge N+1 and held until the next edge.
- Write latency is 1 edge. A read issued in the cycle after the write edge sees the new value regardless of `BYPASS`.
- `busy_vec` reflects the state after the most recent edge (no lookahead).
- **Reset (`rst_n` low, asynchronous):**
  - every register = 0;
  - `busy_vec` = 0;
  - `rd_data` = 0;
  - `rd_busy` = 0.
  - Writes and issues in the reset cycle are discarded.
- Deassertion is synchronised externally. The first write is accepted at the first rising edge with `rst_n` high.
- Reset asserted between a write request and its edge: the write is lost and the register reads 0.

## Structure
- Shared package `rf_pkg`:
  - a `rf_addr_w` function (clog2 with a minimum of 1);
  - the `RF_MAX_RD_PORTS`=4 and `RF_MAX_WR_PORTS`=2 constants;
  - `ZERO_REG`=0.
- Sub-module `rf_scoreboard`:
  - parameters `REG_CNT` and `WR_PORTS`;
  - contains the busy bits, the set/clear priority and a next-state output used by the read-port flag logic.
- Register storage, write priority, bypass muxing and the read registers stay in `regfile_mp`.
- Elaboration-time check: fail if the port counts exceed the package limits or if `REG_CNT` is not a power of two.

## Test plan
- **Reset clear.** Write 0xDEADBEEF to r5, then pulse `rst_n` low mid-cycle. `rd_data` goes 0 immediately; reading r5 returns 0; `busy_vec`=0.
- **x0 and basic R/W.** Write 0x12345678 to r0 and 0xA5A5A5A5 to r7; one cycle later read r0 and r7. Expect 0 and 0xA5A5A5A5 one cycle after the address is presented.
- **Bypass.**
  - `BYPASS`=1: write 0x11 to r3 while reading r3 in the same cycle; `rd_data` = 0x11.
  - `BYPASS`=0: the same stimulus returns the old value 0x0.
- **Write conflict.** `WR_PORTS`=2, both ports write r9 (port0 = 0xAA, port1 = 0xBB). A later read of r9 returns 0xBB.
- **Scoreboard.**
  - Issue r4: `busy_vec[4]`=1 after the edge.
  - Write r4: bit clears.
  - Issue and write r4 in the same cycle: bit is 1.
  - Issue r0: bit stays 0.
- **Busy flag with read.** Read r4 in the cycle its write arrives: `rd_busy`=0 and `rd_data` = the written value (`BYPASS`=1).
